// File: rtl/custom_buff_ctrl.sv
// -----------------------------------------------------------------------------
// custom_buff_ctrl
//
// Sequencer for the shared 8-bit load bus of the feature/weight buffer and
// multiplier. For each of LEN pairs it reads feature[i] and weight[i] from a
// 1-cycle-latency memory. It strobes them into the buffer over data_out. It
// then adds the returned 8-bit product into acc_out. A one-cycle done pulse
// ends the run.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   start      run request, sampled only while idle
//   mem_rd     memory read strobe
//   mem_addr   memory read address (0 when mem_rd is low)
//   mem_data   memory read data, valid the cycle after mem_rd
//   data_out   load bus to the buffer (0 unless a load strobe is high)
//   feature_en load feature register from data_out
//   weight_en  load weight register from data_out
//   mul_in     product from the buffer/ALU
//   busy       high in every state except idle
//   done       one-cycle pulse, acc_out is final
//   acc_out    accumulated sum, holds the last result while idle
//   ovf        sticky: accumulator wrapped during the current run
// -----------------------------------------------------------------------------
module custom_buff_ctrl #(
  parameter int LEN    = 9,
  parameter int ADDR_W = 8,
  parameter int F_BASE = 0,
  parameter int W_BASE = 16,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        data_out,
  output logic              feature_en,
  output logic              weight_en,
  input  logic [7:0]        mul_in,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_F = 3'd1,
    S_LD_F = 3'd2,
    S_LD_W = 3'd3,
    S_ACC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   nxt_idx_s;
  logic [ACC_W:0]     sum_s;
  logic               mem_rd_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic               feature_en_r;
  logic               weight_en_r;
  logic               busy_r;
  logic               done_r;
  logic [ACC_W-1:0]   acc_r;
  logic               ovf_r;

  // Next pair index and widened accumulator sum (MSB is the carry-out).
  always_comb begin
    nxt_idx_s = idx_r + IDX_W'(1);
    sum_s     = (ACC_W+1)'(acc_r) + (ACC_W+1)'(mul_in);
  end

  // Sequencer: every output register is loaded together with the state it
  // belongs to, so outputs change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      idx_r        <= '0;
      mem_rd_r     <= 1'b0;
      mem_addr_r   <= '0;
      feature_en_r <= 1'b0;
      weight_en_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      acc_r        <= '0;
      ovf_r        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r    <= S_RD_F;
            idx_r      <= '0;
            acc_r      <= '0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b1;
            mem_rd_r   <= 1'b1;
            mem_addr_r <= ADDR_W'(F_BASE);
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RD_F: begin
          // Feature arrives now; issue the weight read in the same cycle.
          state_r      <= S_LD_F;
          mem_rd_r     <= 1'b1;
          mem_addr_r   <= ADDR_W'(W_BASE) + ADDR_W'(idx_r);
          feature_en_r <= 1'b1;
        end
        S_LD_F: begin
          state_r      <= S_LD_W;
          mem_rd_r     <= 1'b0;
          mem_addr_r   <= '0;
          feature_en_r <= 1'b0;
          weight_en_r  <= 1'b1;
        end
        S_LD_W: begin
          state_r     <= S_ACC;
          weight_en_r <= 1'b0;
        end
        S_ACC: begin
          acc_r <= sum_s[ACC_W-1:0];
          ovf_r <= ovf_r | sum_s[ACC_W];
          if (idx_r == IDX_W'(LEN - 1)) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r    <= S_RD_F;
            idx_r      <= nxt_idx_s;
            mem_rd_r   <= 1'b1;
            mem_addr_r <= ADDR_W'(F_BASE) + ADDR_W'(nxt_idx_s);
          end
        end
        S_DONE: begin
          // start is deliberately ignored here; it is only seen back in idle.
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r      <= S_IDLE;
          mem_rd_r     <= 1'b0;
          mem_addr_r   <= '0;
          feature_en_r <= 1'b0;
          weight_en_r  <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

  // The memory returns data in the load cycle itself. The load bus therefore
  // passes mem_data through, gated by the registered load strobes.
  assign data_out   = (feature_en_r | weight_en_r) ? mem_data : 8'd0;
  assign mem_rd     = mem_rd_r;
  assign mem_addr   = mem_addr_r;
  assign feature_en = feature_en_r;
  assign weight_en  = weight_en_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign acc_out    = acc_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_custom_buff_ctrl.sv
// Self-checking bench for custom_buff_ctrl. It uses three instances:
//   a: defaults (LEN=9, ACC_W=16)
//   b: ACC_W=8
//   c: LEN=1
// Each instance has its own 1-cycle memory and buffer/multiplier model.
module tb_custom_buff_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  // instance a
  logic start_a, mem_rd_a, fe_a, we_a, busy_a, done_a, ovf_a;
  logic [7:0] addr_a, mdat_a, dout_a, mul_a, f_a, w_a;
  logic [15:0] acc_a;
  // instance b
  logic start_b, mem_rd_b, fe_b, we_b, busy_b, done_b, ovf_b;
  logic [7:0] addr_b, mdat_b, dout_b, mul_b, f_b, w_b;
  logic [7:0] acc_b;
  // instance c
  logic start_c, mem_rd_c, fe_c, we_c, busy_c, done_c, ovf_c;
  logic [7:0] addr_c, mdat_c, dout_c, mul_c, f_c, w_c;
  logic [15:0] acc_c;

  custom_buff_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_rd(mem_rd_a), .mem_addr(addr_a),
    .mem_data(mdat_a), .data_out(dout_a), .feature_en(fe_a), .weight_en(we_a),
    .mul_in(mul_a), .busy(busy_a), .done(done_a), .acc_out(acc_a), .ovf(ovf_a));

  custom_buff_ctrl #(.ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_rd(mem_rd_b), .mem_addr(addr_b),
    .mem_data(mdat_b), .data_out(dout_b), .feature_en(fe_b), .weight_en(we_b),
    .mul_in(mul_b), .busy(busy_b), .done(done_b), .acc_out(acc_b), .ovf(ovf_b));

  custom_buff_ctrl #(.LEN(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .mem_rd(mem_rd_c), .mem_addr(addr_c),
    .mem_data(mdat_c), .data_out(dout_c), .feature_en(fe_c), .weight_en(we_c),
    .mul_in(mul_c), .busy(busy_c), .done(done_c), .acc_out(acc_c), .ovf(ovf_c));

  // Memory (1-cycle read latency) and buffer registers for each instance.
  always @(posedge clk) begin
    if (mem_rd_a) mdat_a <= mem[addr_a];
    if (fe_a) f_a <= dout_a;
    if (we_a) w_a <= dout_a;
    if (mem_rd_b) mdat_b <= mem[addr_b];
    if (fe_b) f_b <= dout_b;
    if (we_b) w_b <= dout_b;
    if (mem_rd_c) mdat_c <= mem[addr_c];
    if (fe_c) f_c <= dout_c;
    if (we_c) w_c <= dout_c;
  end

  wire [15:0] prod_a = f_a * w_a;
  wire [15:0] prod_b = f_b * w_b;
  wire [15:0] prod_c = f_c * w_c;
  assign mul_a = prod_a[7:0];
  assign mul_b = prod_b[7:0];
  assign mul_c = prod_c[7:0];

  // Reference: plain sum of 8-bit products over len pairs, before wrapping.
  function automatic int ref_sum(input int len);
    int s = 0;
    for (int i = 0; i < len; i++) s += (int'(mem[i]) * int'(mem[16+i])) % 256;
    return s;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    for (int i = 0; i < 9; i++) begin
      mem[i]    = 8'(i + 1);
      mem[16+i] = 8'd1;
    end
  endtask

  // Stimulus helper: start pulse in cycle 0, then observe cycles 1..max_cyc.
  task automatic go(input int sel, input int max_cyc, output int done_cyc,
                    output int n_done, output int acc, output logic ovf_o);
    logic d;
    @(negedge clk);
    case (sel)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    done_cyc = -1;
    n_done   = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
      if (d) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    acc   = (sel == 0) ? int'(acc_a) : (sel == 1) ? int'(acc_b) : int'(acc_c);
    ovf_o = (sel == 0) ? ovf_a : (sel == 1) ? ovf_b : ovf_c;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    #1;
    total++;
    if ({busy_a, done_a, mem_rd_a, addr_a, fe_a, we_a, dout_a, acc_a, ovf_a} !== 44'd0) begin
      bad++;
      $display("FAIL reset_a: got busy=%b done=%b rd=%b addr=%0d fe=%b we=%b dout=%0d acc=%0d ovf=%b, want all 0",
               busy_a, done_a, mem_rd_a, addr_a, fe_a, we_a, dout_a, acc_a, ovf_a);
    end
    total++;
    if ({busy_b, acc_b, ovf_b, busy_c, acc_c, ovf_c} !== 28'd0) begin
      bad++;
      $display("FAIL reset_bc: got b busy=%b acc=%0d ovf=%b c busy=%b acc=%0d ovf=%b, want 0",
               busy_b, acc_b, ovf_b, busy_c, acc_c, ovf_c);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Ramp run with a per-cycle bus check derived from the 4-cycle pair slots.
  task automatic test_bus();
    logic [22:0] got, exp;
    int ph, j;
    logic fe, we, rd;
    logic [7:0] ad, dt;
    fill_ramp();
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      ph = (c - 1) % 4;
      j  = (c - 1) / 4;
      rd = (c <= 36) && (ph == 0 || ph == 1);
      fe = (c <= 36) && (ph == 1);
      we = (c <= 36) && (ph == 2);
      ad = !rd ? 8'd0 : (ph == 0) ? 8'(j) : 8'(16 + j);
      dt = fe ? 8'(j + 1) : (we ? 8'd1 : 8'd0);
      exp = {1'(c <= 37), 1'(c == 37), rd, ad, fe, we, dt};
      got = {busy_a, done_a, mem_rd_a, addr_a, fe_a, we_a, dout_a};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL bus cyc %0d: got busy,done,rd,addr,fe,we,data=%b,%b,%b,%0d,%b,%b,%0d want %b,%b,%b,%0d,%b,%b,%0d",
                 c, got[22], got[21], got[20], got[19:12], got[11], got[10], got[9:0] & 10'hff,
                 exp[22], exp[21], exp[20], exp[19:12], exp[11], exp[10], exp[9:0] & 10'hff);
      end
    end
    total++;
    if (acc_a !== 16'd45 || ovf_a !== 1'b0) begin
      bad++;
      $display("FAIL ramp_result: got acc=%0d ovf=%b want acc=45 ovf=0", acc_a, ovf_a);
    end
  endtask

  task automatic test_random();
    int dc, nd, acc, s;
    logic ov;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 9; i++) begin
        mem[i]    = 8'($urandom_range(0, 255));
        mem[16+i] = 8'($urandom_range(0, 255));
      end
      s = ref_sum(9);
      go(it % 2, 40, dc, nd, acc, ov);
      total++;
      if (dc != 37 || nd != 1) begin
        bad++;
        $display("FAIL rand_done it%0d: got cycle %0d count %0d want cycle 37 count 1", it, dc, nd);
      end
      total++;
      if (it % 2 == 0) begin
        if (acc != s % 65536 || ov !== 1'(s >= 65536)) begin
          bad++;
          $display("FAIL rand_a it%0d: got acc=%0d ovf=%b want acc=%0d ovf=%b", it, acc, ov, s % 65536, s >= 65536);
        end
      end else begin
        if (acc != s % 256 || ov !== 1'(s >= 256)) begin
          bad++;
          $display("FAIL rand_b it%0d: got acc=%0d ovf=%b want acc=%0d ovf=%b", it, acc, ov, s % 256, s >= 256);
        end
      end
    end
  endtask

  task automatic test_ovf();
    int dc, nd, acc;
    logic ov;
    for (int i = 0; i < 9; i++) begin
      mem[i]    = 8'd15;
      mem[16+i] = 8'd15;
    end
    go(1, 40, dc, nd, acc, ov);
    total++;
    if (dc != 37 || acc != 233 || ov !== 1'b1) begin
      bad++;
      $display("FAIL ovf_run: got done=%0d acc=%0d ovf=%b want done=37 acc=233 ovf=1", dc, acc, ov);
    end
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    total++;
    if (acc_b !== 8'd0 || ovf_b !== 1'b0 || busy_b !== 1'b1) begin
      bad++;
      $display("FAIL ovf_clear: got acc=%0d ovf=%b busy=%b want 0,0,1", acc_b, ovf_b, busy_b);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_start_held();
    int d1, d2, nd;
    fill_ramp();
    d1 = -1; d2 = -1; nd = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 76; c++) begin
      @(negedge clk);
      if (done_a) begin
        nd++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (c == 38) begin
        total++;
        if (busy_a !== 1'b0 || acc_a !== 16'd45) begin
          bad++;
          $display("FAIL held_idle: got busy=%b acc=%0d want busy=0 acc=45", busy_a, acc_a);
        end
      end
      if (c == 39) begin
        total++;
        if (busy_a !== 1'b1 || acc_a !== 16'd0) begin
          bad++;
          $display("FAIL held_restart: got busy=%b acc=%0d want busy=1 acc=0", busy_a, acc_a);
        end
      end
    end
    start_a = 1'b0;
    total++;
    if (nd != 2 || d1 != 37 || d2 != 75 || acc_a !== 16'd45) begin
      bad++;
      $display("FAIL held_runs: got %0d dones at %0d,%0d acc=%0d want 2 at 37,75 acc=45", nd, d1, d2, acc_a);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc, nd, acc, seen;
    logic ov;
    fill_ramp();
    seen = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (done_a) seen++;
    end
    rst = 1'b0;
    #1;
    total++;
    if ({busy_a, done_a, mem_rd_a, addr_a, fe_a, we_a, dout_a, acc_a, ovf_a} !== 44'd0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b rd=%b addr=%0d fe=%b we=%b dout=%0d acc=%0d ovf=%b want all 0",
               busy_a, mem_rd_a, addr_a, fe_a, we_a, dout_a, acc_a, ovf_a);
    end
    repeat (2) begin
      @(negedge clk);
      if (done_a) seen++;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_a) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_nodone: got %0d done pulses want 0", seen);
    end
    go(0, 40, dc, nd, acc, ov);
    total++;
    if (dc != 37 || nd != 1 || acc != 45 || ov !== 1'b0) begin
      bad++;
      $display("FAIL reset_rerun: got done=%0d n=%0d acc=%0d ovf=%b want 37,1,45,0", dc, nd, acc, ov);
    end
  endtask

  task automatic test_len1();
    int nd;
    fill_ramp();
    mem[0]  = 8'd7;
    mem[16] = 8'd3;
    nd = 0;
    @(negedge clk);
    start_c = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_c = 1'b0;
      total++;
      if (busy_c !== 1'(c <= 5) || done_c !== 1'(c == 5)) begin
        bad++;
        $display("FAIL len1 cyc %0d: got busy=%b done=%b want busy=%b done=%b",
                 c, busy_c, done_c, c <= 5, c == 5);
      end
    end
    total++;
    if (acc_c !== 16'd21 || ovf_c !== 1'b0) begin
      bad++;
      $display("FAIL len1_result: got acc=%0d ovf=%b want acc=21 ovf=0", acc_c, ovf_c);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    test_reset();
    test_bus();
    test_random();
    test_ovf();
    test_start_held();
    test_reset_mid();
    test_len1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
